dma_tile_fetch: RTL and testbench

- DMA stage 2: sits directly upstream of the UART DMA engine and produces its `dma_stage_2_instr`.
- For a main-memory write (`mem_we`=1), reads the 4x4 tile of 18-bit cherry floats from the dcache, one row per read, and packs it into the 288-bit `dat` field.
- For a main-memory read (`mem_we`=0), passes the instruction through with `dat`=0.
- Holds the instruction until the DMA engine is free, then presents it for exactly one cycle.

---
 rtl/dma_tile_fetch_pkg.sv | 34 +++
 rtl/dma_tile_packer.sv | 37 +++
 rtl/dma_tile_fetch.sv | 101 ++++++++++
 tb/tb_dma_tile_fetch.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_tile_fetch_pkg.sv
// Shared types and constants for DMA stage 2 (tile fetch ahead of the UART DMA engine).
package dma_tile_fetch_pkg;

   localparam int TILE_ROWS    = 4;
   localparam int ROW_ELEMS    = 4;
   localparam int ELEM_W       = 18;
   localparam int CACHE_ADDR_W = 12;
   localparam int ROW_BITS     = ROW_ELEMS * ELEM_W;   // 72
   localparam int TILE_BITS    = TILE_ROWS * ROW_BITS; // 288

   typedef struct packed {
      logic                    valid;
      logic                    mem_we;
      logic [15:0]             main_mem_addr;
      logic [CACHE_ADDR_W-1:0] cache_addr;
   } raw_instr_t;

   typedef struct packed {
      raw_instr_t raw_instr_data;
   } dma_stage_1_instr;

   typedef struct packed {
      raw_instr_t           raw_instr_data;
      logic [TILE_BITS-1:0] dat;
   } dma_stage_2_instr;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_COOLDOWN
   } fetch_state_t;

endpackage

// File: rtl/dma_tile_packer.sv
// Row shift buffer for one tile: each load shifts left by one row and inserts
// the new row at the LSB, so the first row read ends up at the MSB end.
module dma_tile_packer
   import dma_tile_fetch_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 clear,
   input  logic [ROW_BITS-1:0]  row_data,
   output logic                 full,
   output logic [TILE_BITS-1:0] dat
);

   localparam int CNT_W = $clog2(TILE_ROWS + 1);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(TILE_ROWS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] recv_cnt;

   // High together with the load that completes the tile, so the fetch FSM can
   // leave FETCH on the same edge that captures the last row.
   assign full = load && (recv_cnt == LAST_ROW);

   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments only, so every register
      // here sees the pre-edge value of every other register.
      if (reset || clear) begin
         recv_cnt <= '0;
         dat      <= '0;
      end else if (load) begin
         recv_cnt <= recv_cnt + CNT_ONE;
         dat      <= {dat[TILE_BITS-ROW_BITS-1:0], row_data};
      end
   end

endmodule

// File: rtl/dma_tile_fetch.sv
// DMA stage 2: for memory writes, gathers a 4x4 tile from the dcache into dat;
// for memory reads, passes the instruction through. Issues one cycle per instruction.
module dma_tile_fetch
   import dma_tile_fetch_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  dma_stage_1_instr        in_instr,
   output logic                    in_ready,
   input  logic                    dma_busy,
   output dma_stage_2_instr        out_instr,
   output logic                    cache_rd_en,
   output logic [CACHE_ADDR_W-1:0] cache_rd_addr,
   input  logic [ROW_BITS-1:0]     cache_rd_data
);

   localparam int CNT_W = $clog2(TILE_ROWS + 1);
   localparam logic [CNT_W-1:0] ROWS_N  = CNT_W'(TILE_ROWS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   fetch_state_t         state;
   raw_instr_t           instr_q;
   logic [CNT_W-1:0]     issue_cnt;
   logic                 rd_valid_q;
   logic                 accept;
   logic                 tile_done;
   logic [TILE_BITS-1:0] tile_dat;

   assign in_ready = (state == S_IDLE);
   assign accept   = in_ready && in_instr.raw_instr_data.valid;

   // Cleared on every accept, so a read-mode issue carries dat=0 and a new tile
   // never inherits rows from the previous one.
   dma_tile_packer u_packer (
      .clk      (clk),
      .reset    (reset),
      .load     (rd_valid_q),
      .clear    (accept),
      .row_data (cache_rd_data),
      .full     (tile_done),
      .dat      (tile_dat)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         instr_q       <= '0;
         issue_cnt     <= '0;
         cache_rd_en   <= 1'b0;
         cache_rd_addr <= '0;
         rd_valid_q    <= 1'b0;
      end else begin
         rd_valid_q  <= cache_rd_en;
         cache_rd_en <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  instr_q <= in_instr.raw_instr_data;
                  if (in_instr.raw_instr_data.mem_we) begin
                     // Row 0 is requested on the accept edge so the four reads
                     // occupy the four cycles straight after accept.
                     state         <= S_FETCH;
                     cache_rd_en   <= 1'b1;
                     cache_rd_addr <= in_instr.raw_instr_data.cache_addr;
                     issue_cnt     <= CNT_ONE;
                  end else begin
                     state <= S_ISSUE;
                  end
               end
            end
            S_FETCH: begin
               if (issue_cnt < ROWS_N) begin
                  cache_rd_en   <= 1'b1;
                  cache_rd_addr <= instr_q.cache_addr + CACHE_ADDR_W'(issue_cnt);
                  issue_cnt     <= issue_cnt + CNT_ONE;
               end
               if (tile_done) state <= S_ISSUE;
            end
            S_ISSUE: begin
               if (!dma_busy) state <= S_COOLDOWN;
            end
            S_COOLDOWN: begin
               // The engine raises busy one cycle after valid; wait it out.
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Issue reacts to busy in the same cycle, so valid is gated combinationally.
   always_comb begin
      // NOTE: default first so every path assigns out_instr and no latch is inferred.
      out_instr = '0;
      if (state == S_ISSUE && !dma_busy) begin
         out_instr.raw_instr_data = instr_q;
         out_instr.dat            = tile_dat;
      end
   end

endmodule

// File: tb/tb_dma_tile_fetch.sv
// Self-checking bench for dma_tile_fetch: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_dma_tile_fetch;
   import dma_tile_fetch_pkg::*;

   localparam int MAXC = 8192;

   logic                    clk;
   logic                    reset;
   dma_stage_1_instr        in_instr;
   logic                    in_ready;
   logic                    dma_busy;
   dma_stage_2_instr        out_instr;
   logic                    cache_rd_en;
   logic [CACHE_ADDR_W-1:0] cache_rd_addr;
   logic [ROW_BITS-1:0]     cache_rd_data;

   dma_tile_fetch dut (
      .clk           (clk),
      .reset         (reset),
      .in_instr      (in_instr),
      .in_ready      (in_ready),
      .dma_busy      (dma_busy),
      .out_instr     (out_instr),
      .cache_rd_en   (cache_rd_en),
      .cache_rd_addr (cache_rd_addr),
      .cache_rd_data (cache_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic rand_busy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // dcache model: row data one cycle after the strobe, junk otherwise.
   logic [ROW_BITS-1:0] mem [4096];
   always @(posedge clk) begin
      if (cache_rd_en) cache_rd_data <= mem[cache_rd_addr];
      else             cache_rd_data <= 72'({$urandom(), $urandom(), $urandom()});
   end

   typedef struct { int c; logic [11:0] a; } rd_t;
   typedef struct { int c; dma_stage_2_instr ins; } iss_t;
   rd_t  rd_q[$];
   iss_t iss_q[$];
   logic rdy_hist  [MAXC];
   logic busy_hist [MAXC];
   logic outz_hist [MAXC];

   always @(negedge clk) begin
      if (cyc < MAXC) begin
         rdy_hist[cyc]  = in_ready;
         busy_hist[cyc] = dma_busy;
         outz_hist[cyc] = (out_instr == '0);
      end
      if (!reset && cache_rd_en) rd_q.push_back('{cyc, cache_rd_addr});
      if (out_instr.raw_instr_data.valid) iss_q.push_back('{cyc, out_instr});
   end

   task automatic check(input string name, input logic [319:0] got, input logic [319:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_busy) dma_busy = ($urandom_range(0, 2) == 0);
   endtask

   // Expected tile: row i of the fetch lands in slot i counted from the MSB end.
   function automatic logic [TILE_BITS-1:0] model_dat(input logic we, input logic [11:0] ca);
      logic [TILE_BITS-1:0] d;
      d = '0;
      if (we)
         for (int i = 0; i < TILE_ROWS; i++)
            d[TILE_BITS-1-ROW_BITS*i -: ROW_BITS] = mem[ca + 12'(i)];
      return d;
   endfunction

   task automatic send(input logic we, input logic [15:0] mm, input logic [11:0] ca, output int t);
      logic ok;
      ok = 1'b0;
      t  = -1;
      in_instr.raw_instr_data.valid         = 1'b1;
      in_instr.raw_instr_data.mem_we        = we;
      in_instr.raw_instr_data.main_mem_addr = mm;
      in_instr.raw_instr_data.cache_addr    = ca;
      for (int k = 0; k < 300 && !ok; k++) begin
         if (in_ready) begin
            ok = 1'b1;
            t  = cyc;
         end
         tick();
      end
      check("accepted", 320'(ok), 320'(1'b1));
   endtask

   dma_stage_2_instr last_out;

   task automatic verify(input string name, input logic we, input logic [15:0] mm,
                         input logic [11:0] ca, input int t, input int exp_issue,
                         input logic [3:0][11:0] exp_a, input logic use_model,
                         output int issue_c);
      iss_t             it;
      rd_t              r;
      logic             seen;
      logic             no_rd;
      int               lat;
      dma_stage_2_instr exp_o;
      seen    = 1'b0;
      issue_c = -1;
      for (int k = 0; k < 400 && !seen; k++) begin
         if (iss_q.size() > 0) seen = 1'b1;
         else tick();
      end
      check({name, ":issue_seen"}, 320'(seen), 320'(1'b1));
      if (!seen) return;
      it       = iss_q.pop_front();
      issue_c  = it.c;
      last_out = it.ins;
      lat      = we ? 6 : 1;
      if (use_model) begin
         exp_issue = -1;
         for (int c = t + lat; c < cyc && exp_issue < 0; c++)
            if (!busy_hist[c]) exp_issue = c;
         for (int i = 0; i < TILE_ROWS; i++) exp_a[i] = ca + 12'(i);
      end
      check({name, ":issue_cycle"}, 320'(it.c), 320'(exp_issue));
      exp_o.raw_instr_data.valid         = 1'b1;
      exp_o.raw_instr_data.mem_we        = we;
      exp_o.raw_instr_data.main_mem_addr = mm;
      exp_o.raw_instr_data.cache_addr    = ca;
      exp_o.dat                          = model_dat(we, ca);
      check({name, ":out_instr"}, 320'(it.ins), 320'(exp_o));
      if (we) begin
         check({name, ":rd_count"}, 320'(rd_q.size() >= TILE_ROWS), 320'(1'b1));
         for (int i = 0; i < TILE_ROWS && rd_q.size() > 0; i++) begin
            r = rd_q.pop_front();
            check({name, ":rd_cycle"}, 320'(r.c), 320'(t + 1 + i));
            check({name, ":rd_addr"}, 320'(r.a), 320'(exp_a[i]));
         end
      end else begin
         no_rd = (rd_q.size() == 0) || (rd_q[0].c > it.c);
         check({name, ":no_reads"}, 320'(no_rd), 320'(1'b1));
      end
      while (cyc <= it.c + 2) tick();
      check({name, ":cooldown_out_zero"}, 320'(outz_hist[it.c + 1]), 320'(1'b1));
      check({name, ":cooldown_not_ready"}, 320'(rdy_hist[it.c + 1]), 320'(1'b0));
      check({name, ":ready_after_issue"}, 320'(rdy_hist[it.c + 2]), 320'(1'b1));
   endtask

   typedef struct {
      string            name;
      logic             we;
      logic [15:0]      mm;
      logic [11:0]      ca;
      int               hold;
      int               exp_lat;
      logic [3:0][11:0] exp_a;
   } vec_t;

   function automatic vec_t mk(input string n, input logic we, input logic [15:0] mm,
                               input logic [11:0] ca, input int hold, input int exp_lat,
                               input logic [11:0] a0, a1, a2, a3);
      vec_t v;
      v.name    = n;
      v.we      = we;
      v.mm      = mm;
      v.ca      = ca;
      v.hold    = hold;
      v.exp_lat = exp_lat;
      v.exp_a   = {a3, a2, a1, a0};
      return v;
   endfunction

   localparam logic [71:0] ROW10 = 72'h1111_1111_1111_1111_A1;
   localparam logic [71:0] ROW11 = 72'h2222_2222_2222_2222_B2;
   localparam logic [71:0] ROW12 = 72'h3333_3333_3333_3333_C3;
   localparam logic [71:0] ROW13 = 72'h4444_4444_4444_4444_D4;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[5];
      int   t, ta, tb, tc, ia, ib, ic, ix, nz, lat0;

      for (int i = 0; i < 4096; i++) mem[i] = 72'({$urandom(), $urandom(), $urandom()});
      mem[12'h010] = ROW10;
      mem[12'h011] = ROW11;
      mem[12'h012] = ROW12;
      mem[12'h013] = ROW13;

      vecs[0] = mk("wr_fetch",  1'b1, 16'hBEEF, 12'h010, 0,  6, 12'h010, 12'h011, 12'h012, 12'h013);
      vecs[1] = mk("rd_pass",   1'b0, 16'h1234, 12'h055, 0,  1, 12'h000, 12'h000, 12'h000, 12'h000);
      vecs[2] = mk("backpr",    1'b1, 16'h4321, 12'h200, 50, 56, 12'h200, 12'h201, 12'h202, 12'h203);
      vecs[3] = mk("wrap",      1'b1, 16'h0F0F, 12'hFFE, 0,  6, 12'hFFE, 12'hFFF, 12'h000, 12'h001);
      vecs[4] = mk("rd_backpr", 1'b0, 16'hA5A5, 12'h000, 5,  6, 12'h000, 12'h000, 12'h000, 12'h000);

      reset    = 1'b1;
      in_instr = '0;
      dma_busy = 1'b0;
      repeat (3) tick();
      check("rst:in_ready", 320'(in_ready), 320'(1'b1));
      check("rst:cache_rd_en", 320'(cache_rd_en), 320'(1'b0));
      check("rst:cache_rd_addr", 320'(cache_rd_addr), 320'(0));
      check("rst:out_instr", 320'(out_instr), 320'(0));
      reset = 1'b0;
      tick();

      for (int v = 0; v < 5; v++) begin
         dma_busy = (vecs[v].hold > 0);
         send(vecs[v].we, vecs[v].mm, vecs[v].ca, t);
         in_instr = '0;
         lat0 = vecs[v].we ? 6 : 1;
         if (vecs[v].hold > 0) begin
            while (cyc < t + lat0 + vecs[v].hold) tick();
            dma_busy = 1'b0;
            nz = 0;
            for (int c = t + 1; c < cyc; c++) if (rdy_hist[c]) nz++;
            check({vecs[v].name, ":ready_low_while_busy"}, 320'(nz), 320'(0));
         end
         verify(vecs[v].name, vecs[v].we, vecs[v].mm, vecs[v].ca, t, t + vecs[v].exp_lat,
                vecs[v].exp_a, 1'b0, ix);
         if (v == 0) begin
            check("wr_fetch:row0_at_msb", 320'(last_out.dat[287:216]), 320'(ROW10));
            check("wr_fetch:tile", 320'(last_out.dat), 320'({ROW10, ROW11, ROW12, ROW13}));
         end
      end

      // Reset during FETCH abandons the instruction.
      send(1'b1, 16'h7777, 12'h123, t);
      in_instr = '0;
      while (cyc < t + 3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid:in_ready", 320'(in_ready), 320'(1'b1));
      check("rst_mid:cache_rd_en", 320'(cache_rd_en), 320'(1'b0));
      repeat (30) tick();
      check("rst_mid:no_issue", 320'(iss_q.size()), 320'(0));
      rd_q.delete();

      // Back-to-back: valid held high across three instructions.
      send(1'b1, 16'h1111, 12'h300, ta);
      send(1'b0, 16'h2222, 12'h7AB, tb);
      send(1'b1, 16'h3333, 12'h304, tc);
      in_instr = '0;
      verify("b2b_a", 1'b1, 16'h1111, 12'h300, ta, 0, '0, 1'b1, ia);
      verify("b2b_b", 1'b0, 16'h2222, 12'h7AB, tb, 0, '0, 1'b1, ib);
      verify("b2b_c", 1'b1, 16'h3333, 12'h304, tc, 0, '0, 1'b1, ic);
      check("b2b:b_accept_when_ready", 320'(tb), 320'(ia + 2));
      check("b2b:spacing_ab", 320'(ib - ia >= 3), 320'(1'b1));
      check("b2b:spacing_bc", 320'(ic - ib >= 3), 320'(1'b1));

      // Randomized traffic with random engine backpressure.
      rand_busy = 1'b1;
      for (int n = 0; n < 40; n++) begin
         logic        we;
         logic [15:0] mm;
         logic [11:0] ca;
         we = 1'($urandom_range(0, 1));
         mm = 16'($urandom());
         ca = ($urandom_range(0, 3) == 0) ? 12'(12'hFFC + $urandom_range(0, 3)) : 12'($urandom());
         send(we, mm, ca, t);
         in_instr = '0;
         verify("rand", we, mm, ca, t, 0, '0, 1'b1, ix);
      end
      rand_busy = 1'b0;
      dma_busy  = 1'b0;
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
